// File: rtl/rv32_scoreboard.sv
// Register scoreboard and issue gate between decode and execute.
// Optional stall statistics are enabled with `define SCOREBOARD_STATS_EN.
module rv32_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [NUM_READ*5-1:0] issue_rs_idx,
    input  logic [NUM_READ-1:0]   issue_use_rs,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_wb,
    input  logic                  issue_long,
    input  logic                  issue_serialize,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_rd,
    output logic                  pending_any
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]           stall_raw_cnt,
    output logic [31:0]           stall_drain_cnt
`endif
);

    localparam int unsigned IDX_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] eff     [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic             any_eff;
    logic             pend_nxt;
    logic             raw_hazard;
    logic             rd_hazard;
    logic             drain_block;
    logic             fire;
    logic [CNT_W-1:0] rd_eff;
    logic [IDX_W-1:0] slot_idx;

    // Writeback bypass: a retiring writeback already frees its register this cycle.
    // Writebacks to x0 or to an idle counter are dropped so nothing underflows.
    always_comb begin
        dec     = '0;
        any_eff = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            eff[r] = '0;
            if (r != 0) begin
                dec[r] = wb_valid && (wb_rd == IDX_W'(r)) && (cnt[r] != '0);
                eff[r] = cnt[r] - CNT_W'(dec[r]);
            end
            any_eff = any_eff || (eff[r] != '0);
        end
    end

    // Hazard detection against the bypassed counts.
    always_comb begin
        raw_hazard = 1'b0;
        slot_idx   = '0;
        for (int i = 0; i < int'(NUM_READ); i++) begin
            slot_idx = issue_rs_idx[IDX_W*i +: IDX_W];
            if (issue_use_rs[i] && (slot_idx != '0) && (eff[slot_idx] != '0)) begin
                raw_hazard = 1'b1;
            end
        end
        rd_eff = eff[issue_rd];
        rd_hazard = 1'b0;
        if (issue_wb && (issue_rd != '0)) begin
            rd_hazard = issue_long ? (rd_eff == CNT_MAX) : (rd_eff != '0);
        end
        drain_block = any_eff && (issue_serialize || (state == DRAIN));
        issue_ready = !rst && !flush && !raw_hazard && !rd_hazard && !drain_block;
        fire        = issue_valid && issue_ready;
    end

    // Next-state counters; a simultaneous issue and writeback cancel out.
    always_comb begin
        inc      = '0;
        pend_nxt = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            cnt_nxt[r] = '0;
            if (r != 0) begin
                inc[r]     = fire && issue_wb && issue_long && (issue_rd == IDX_W'(r));
                cnt_nxt[r] = cnt[r] + CNT_W'(inc[r]) - CNT_W'(dec[r]);
            end
            pend_nxt = pend_nxt || (cnt_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                cnt[r] <= '0;
            end
            state       <= IDLE;
            pending_any <= 1'b0;
        end else begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            pending_any <= pend_nxt;
            case (state)
                IDLE: begin
                    if (issue_valid && issue_serialize && any_eff && !flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush || !any_eff) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCOREBOARD_STATS_EN
    // Saturating stall counters, observation only.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_raw_cnt   <= '0;
            stall_drain_cnt <= '0;
        end else begin
            if (issue_valid && raw_hazard && !flush && (stall_raw_cnt != 32'hFFFF_FFFF)) begin
                stall_raw_cnt <= stall_raw_cnt + 32'd1;
            end
            if (issue_valid && (state == DRAIN) && (stall_drain_cnt != 32'hFFFF_FFFF)) begin
                stall_drain_cnt <= stall_drain_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32_scoreboard.sv
// Directed self-checking bench for rv32_scoreboard (default build, stats disabled).
module tb_rv32_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [9:0]  issue_rs_idx;
    logic [1:0]  issue_use_rs;
    logic [4:0]  issue_rd;
    logic        issue_wb;
    logic        issue_long;
    logic        issue_serialize;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        pending_any;

    int tests_run;
    int tests_failed;

    rv32_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_rs_idx    (issue_rs_idx),
        .issue_use_rs    (issue_use_rs),
        .issue_rd        (issue_rd),
        .issue_wb        (issue_wb),
        .issue_long      (issue_long),
        .issue_serialize (issue_serialize),
        .flush           (flush),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .pending_any     (pending_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction presented by decode; inputs change 1 time unit after posedge.
    task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [1:0] use_rs, input logic [4:0] rd,
                             input logic wb, input logic lng, input logic ser);
        issue_valid     = v;
        issue_rs_idx    = {rs2, rs1};
        issue_use_rs    = use_rs;
        issue_rd        = rd;
        issue_wb        = wb;
        issue_long      = lng;
        issue_serialize = ser;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v;
        wb_rd    = rd;
    endtask

    task automatic quiet();
        set_instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0);
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        tick();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: issue_ready=%0b expected 0", issue_ready);
        end
        tick();
        tests_run++;
        if (pending_any !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pending: pending_any=%0b expected 0", pending_any);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        quiet();
    endtask

    task automatic test_raw_bypass();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_load_issue: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        tests_run++;
        if (pending_any !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_pending: pending_any=%0b expected 1", pending_any);
        end
        set_instr(1'b1, 5'd5, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_stall: issue_ready=%0b expected 0", issue_ready);
        end
        tick();
        set_wb(1'b1, 5'd5);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_bypass_ready: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        tests_run++;
        if (pending_any !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_cnt_cleared: pending_any=%0b expected 0", pending_any);
        end
        quiet();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
            #1;
            tests_run++;
            if (issue_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL sat_issue%0d: issue_ready=%0b expected 1", k, issue_ready);
            end
            tick();
        end
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_fourth_stall: issue_ready=%0b expected 0", issue_ready);
        end
        tick();
        set_wb(1'b1, 5'd7);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_fourth_with_wb: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        // Probe without firing: counter must still be 3.
        set_wb(1'b0, 5'd0);
        issue_valid = 1'b0;
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_still_full: issue_ready=%0b expected 0", issue_ready);
        end
        // Three writebacks must be required before x7 is free.
        for (int k = 0; k < 3; k++) begin
            set_instr(1'b0, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
            #1;
            tests_run++;
            if (issue_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL sat_drain_pre%0d: issue_ready=%0b expected 0", k, issue_ready);
            end
            set_wb(1'b1, 5'd7);
            tick();
            set_wb(1'b0, 5'd0);
        end
        #1;
        tests_run++;
        if (pending_any !== 1'b0 || issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_drained: pending_any=%0b issue_ready=%0b expected 0 1",
                     pending_any, issue_ready);
        end
        quiet();
    endtask

    task automatic test_no_use_and_x0();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 5'd5, 5'd5, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_use_rs: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        set_instr(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_x0: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        set_instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_to_pending_rd: issue_ready=%0b expected 0", issue_ready);
        end
        quiet();
        set_wb(1'b1, 5'd5);
        tick();
        set_wb(1'b0, 5'd0);
        tests_run++;
        if (pending_any !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_no_count: pending_any=%0b expected 0", pending_any);
        end
    endtask

    task automatic test_serialize_drain();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0, 1'b1);
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL csr_enter_drain: issue_ready=%0b expected 0", issue_ready);
        end
        tick();
        set_wb(1'b1, 5'd3);
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL csr_after_x3: issue_ready=%0b expected 0", issue_ready);
        end
        tick();
        set_wb(1'b1, 5'd9);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL csr_after_x9: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        set_wb(1'b0, 5'd0);
        #1;
        tests_run++;
        if (pending_any !== 1'b0 || issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL csr_back_idle: pending_any=%0b issue_ready=%0b expected 0 1",
                     pending_any, issue_ready);
        end
        tick();
        quiet();
    endtask

    task automatic test_inc_dec_and_stray();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        set_wb(1'b1, 5'd4);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL incdec_ready: issue_ready=%0b expected 1", issue_ready);
        end
        tick();
        // cnt[4] must be exactly 1: one more writeback empties everything.
        issue_valid = 1'b0;
        tick();
        set_wb(1'b0, 5'd0);
        tests_run++;
        if (pending_any !== 1'b0) begin
            tests_failed++;
            $display("FAIL incdec_cnt_one: pending_any=%0b expected 0", pending_any);
        end
        quiet();
        set_wb(1'b1, 5'd8);
        tick();
        set_wb(1'b0, 5'd0);
        set_instr(1'b0, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (pending_any !== 1'b0 || issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stray_wb_x8: pending_any=%0b issue_ready=%0b expected 0 1",
                     pending_any, issue_ready);
        end
        quiet();
    endtask

    task automatic test_flush();
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        tests_run++;
        if (issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_ready: issue_ready=%0b expected 0", issue_ready);
        end
        tick();
        flush = 1'b0;
        set_instr(1'b0, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (pending_any !== 1'b0 || issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_no_inc: pending_any=%0b issue_ready=%0b expected 0 1",
                     pending_any, issue_ready);
        end
        quiet();
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 2; k++) begin
            set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0);
            tick();
        end
        set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 1'b1);
        tick();
        #1;
        tests_run++;
        if (issue_ready !== 1'b0 || pending_any !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_before_rst: issue_ready=%0b pending_any=%0b expected 0 1",
                     issue_ready, pending_any);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (pending_any !== 1'b0 || issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_drain: pending_any=%0b issue_ready=%0b expected 0 1",
                     pending_any, issue_ready);
        end
        set_instr(1'b0, 5'd2, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_cleared_x2: issue_ready=%0b expected 1", issue_ready);
        end
        quiet();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        quiet();
        test_reset();
        test_raw_bypass();
        test_saturation();
        test_no_use_and_x0();
        test_serialize_drain();
        test_inc_dec_and_stray();
        test_flush();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
